// File: rtl/fft64_pkg.sv
// Shared constants and helpers for the 64-point radix-4 FFT.
// Holds twiddle ROM geometry, sequencer state codes and digit reversal.
package fft64_pkg;

    localparam int FFT_N         = 64;
    localparam int TW_ADDRLENGTH = 6;
    localparam int TW_WORDLENGTH = 18;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // Reverse the base-4 digit order of a twiddle-ROM index
    function automatic logic [TW_ADDRLENGTH-1:0] digit_rev4_fn(
        input logic [TW_ADDRLENGTH-1:0] n
    );
        logic [TW_ADDRLENGTH-1:0] r;
        r = '0;
        for (int d = 0; d < TW_ADDRLENGTH / 2; d++) begin
            r[2*d +: 2] = n[TW_ADDRLENGTH-2-2*d +: 2];
        end
        return r;
    endfunction

endpackage

// File: rtl/omega3_seq_digit_rev4.sv
// Combinational base-4 digit reversal of a sample index.
// Shared by the stage sequencers that need reversed ROM order.
module digit_rev4
    import fft64_pkg::*;
#(
    parameter int ADDRLENGTH = TW_ADDRLENGTH
) (
    input  logic [ADDRLENGTH-1:0] n_i,
    output logic [ADDRLENGTH-1:0] rev_o
);

    if (ADDRLENGTH == TW_ADDRLENGTH) begin : g_pkg
        assign rev_o = digit_rev4_fn(n_i);
    end else begin : g_gen
        // Generic widths: swap 2-bit digits end for end
        always_comb begin
            rev_o = '0;
            for (int d = 0; d < ADDRLENGTH / 2; d++) begin
                rev_o[2*d +: 2] = n_i[ADDRLENGTH-2-2*d +: 2];
            end
        end
    end

endmodule

// File: rtl/omega3_seq.sv
// Stage-3 twiddle ROM address sequencer.
// Walks the ROM once per frame and aligns strobes with ROM output.
module omega3_seq
    import fft64_pkg::*;
#(
    parameter int ADDRLENGTH = TW_ADDRLENGTH,
    parameter int DIGIT_REV  = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic [ADDRLENGTH-1:0] ROM_addr,
    output logic                  tw_valid,
    output logic                  tw_first,
    output logic                  tw_last,
    output logic                  busy,
    output logic                  done,
    output logic                  err_overrun,
    output logic [7:0]            frame_cnt
);

    localparam logic [ADDRLENGTH-1:0] N_ONE = 1;

    logic [1:0]            state_q, state_d;
    logic [ADDRLENGTH-1:0] n_q, n_d;
    logic [ADDRLENGTH-1:0] addr_q, addr_d;
    logic                  issue_q, issue_d;
    logic                  first_q, first_d;
    logic                  last_q, last_d;
    logic                  tw_valid_q, tw_valid_d;
    logic                  tw_first_q, tw_first_d;
    logic                  tw_last_q, tw_last_d;
    logic                  err_q, err_d;
    logic [7:0]            cnt_q, cnt_d;

    logic [ADDRLENGTH-1:0] n_rev;
    logic [ADDRLENGTH-1:0] addr_map;
    logic                  n_last;

    digit_rev4 #(
        .ADDRLENGTH(ADDRLENGTH)
    ) u_map (
        .n_i  (n_q),
        .rev_o(n_rev)
    );

    assign addr_map = (DIGIT_REV != 0) ? n_rev : n_q;
    assign n_last   = (n_q == '1);

    // Next-state: FSM, index counter, address and strobe pipeline
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        addr_d     = addr_q;
        issue_d    = 1'b0;
        first_d    = first_q;
        last_d     = last_q;
        tw_valid_d = issue_q;
        tw_first_d = issue_q & first_q;
        tw_last_d  = issue_q & last_q;
        err_d      = start && (state_q != ST_IDLE);
        cnt_d      = (issue_q && last_q) ? cnt_q + 8'd1 : cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    n_d     = '0;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    issue_d = 1'b1;
                    addr_d  = addr_map;
                    first_d = (n_q == '0);
                    last_d  = n_last;
                    n_d     = n_q + N_ONE;
                    if (n_last) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort drops everything in flight but leaves the ROM address alone
        if (abort) begin
            state_d    = ST_IDLE;
            n_d        = '0;
            addr_d     = addr_q;
            issue_d    = 1'b0;
            first_d    = 1'b0;
            last_d     = 1'b0;
            tw_valid_d = 1'b0;
            tw_first_d = 1'b0;
            tw_last_d  = 1'b0;
            cnt_d      = cnt_q;
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            n_q        <= '0;
            addr_q     <= '0;
            issue_q    <= 1'b0;
            first_q    <= 1'b0;
            last_q     <= 1'b0;
            tw_valid_q <= 1'b0;
            tw_first_q <= 1'b0;
            tw_last_q  <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= 8'd0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            addr_q     <= addr_d;
            issue_q    <= issue_d;
            first_q    <= first_d;
            last_q     <= last_d;
            tw_valid_q <= tw_valid_d;
            tw_first_q <= tw_first_d;
            tw_last_q  <= tw_last_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ROM_addr    = addr_q;
    assign tw_valid    = tw_valid_q;
    assign tw_first    = tw_first_q;
    assign tw_last     = tw_last_q;
    assign done        = tw_last_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_overrun = err_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_omega3_seq.sv
// Self-checking bench for omega3_seq with a stub twiddle ROM.
// Natural and digit-reversed instances share one stimulus stream.
module tb_omega3_seq;

    typedef struct {
        int due;
        int n;
    } sb_t;

    typedef struct {
        int          n;
        logic [5:0]  rev_addr;
        bit          chk_nat;
        logic [17:0] nat_data;
        bit          chk_rev;
        logic [17:0] rev_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic in_valid = 1'b0;

    logic [5:0] a0, a1;
    logic tv0, tf0, tl0, busy0, done0, err0;
    logic tv1, tf1, tl1, busy1, done1, err1;
    logic [7:0] fc0, fc1;

    logic [17:0] rd0, rd1, prev_rd0;
    logic [5:0]  ra0, ra1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int tw_cnt = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    bit gap_chk = 1'b0;
    int idx1 = 0;

    sb_t sb[$];
    logic [5:0]  log0_addr[64];
    logic [17:0] log0_data[64];
    logic [5:0]  log1_addr[64];
    logic [17:0] log1_data[64];

    omega3_seq #(.ADDRLENGTH(6), .DIGIT_REV(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .ROM_addr(a0), .tw_valid(tv0),
        .tw_first(tf0), .tw_last(tl0), .busy(busy0), .done(done0),
        .err_overrun(err0), .frame_cnt(fc0)
    );

    omega3_seq #(.ADDRLENGTH(6), .DIGIT_REV(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in_valid(in_valid), .ROM_addr(a1), .tw_valid(tv1),
        .tw_first(tf1), .tw_last(tl1), .busy(busy1), .done(done1),
        .err_overrun(err1), .frame_cnt(fc1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] rom_lut(input logic [5:0] a);
        case (a)
            6'd5:    return 18'b011101011110011111;
            6'd10:   return 18'b000000000100000001;
            6'd57:   return 18'b001111000100100000;
            default: return {a, ~a, a ^ 6'h15};
        endcase
    endfunction

    // Stub ROM: one registered read per clock
    always @(posedge clk) begin
        rd0 <= rom_lut(a0);
        ra0 <= a0;
        rd1 <= rom_lut(a1);
        ra1 <= a1;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Scoreboard consumer and event counters
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                chk("sb_missing_n", 32'(sb[0].due), 32'(cyc));
                void'(sb.pop_front());
            end
            if (tv0) begin
                if (sb.size() == 0) begin
                    chk("sb_spurious", 32'(tv0), 32'd0);
                end else begin
                    sb_t it;
                    it = sb.pop_front();
                    chk("sb_due", 32'(cyc), 32'(it.due));
                    chk("sb_addr", 32'(ra0), 32'(it.n));
                    chk("sb_data", 32'(rd0), 32'(rom_lut(6'(it.n))));
                    chk("sb_first", 32'(tf0), 32'(it.n == 0));
                    chk("sb_last", 32'(tl0), 32'(it.n == 63));
                    chk("sb_done", 32'(done0), 32'(it.n == 63));
                    log0_addr[it.n] = ra0;
                    log0_data[it.n] = rd0;
                    tw_cnt++;
                end
            end
            if (gap_chk && busy0 && !tv0) begin
                chk("gap_hold", 32'(rd0), 32'(prev_rd0));
            end
            prev_rd0 = rd0;
            if (done0) done_cnt++;
            if (err0) err_cnt++;
            if (tv1) begin
                if (tf1) idx1 = 0;
                if (idx1 < 64) begin
                    log1_addr[idx1] = ra1;
                    log1_data[idx1] = rd1;
                end
                idx1++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_start"}, 32'(busy0), 32'd1);
    endtask

    // Drive samples; toggle selects 1,0,1,0 pacing; stop_at cuts the frame
    task automatic run_issues(input bit toggle, input int stop_at,
                              input int over_at);
        int n = 0;
        int k = 0;
        while (n < 64 && n != stop_at) begin
            logic iv;
            iv = toggle ? logic'(k % 2 == 0) : 1'b1;
            in_valid = iv;
            start = (n == over_at) && iv;
            if (iv) begin
                sb.push_back('{cyc + 2, n});
                n++;
            end
            k++;
            tick();
        end
        in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    vec_t tab[7];
    int tw0, dn0, er0;

    initial begin
        tab[0] = '{0,  6'b000000, 1'b0, 18'd0, 1'b0, 18'd0};
        tab[1] = '{1,  6'b010000, 1'b0, 18'd0, 1'b0, 18'd0};
        tab[2] = '{6,  6'b100100, 1'b0, 18'd0, 1'b0, 18'd0};
        tab[3] = '{27, 6'b111001, 1'b0, 18'd0, 1'b1,
                   18'b001111000100100000};
        tab[4] = '{5,  6'b010100, 1'b1, 18'b011101011110011111,
                   1'b0, 18'd0};
        tab[5] = '{10, 6'b101000, 1'b1, 18'b000000000100000001,
                   1'b0, 18'd0};
        tab[6] = '{63, 6'b111111, 1'b0, 18'd0, 1'b0, 18'd0};

        repeat (2) @(posedge clk);
        #3;
        chk("rst_addr", 32'(a0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_tv", 32'(tv0), 32'd0);
        chk("rst_fc", 32'(fc0), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle_done", 32'(done0), 32'd0);
        chk("idle_err", 32'(err0), 32'd0);

        // Frame A: natural order, in_valid held high
        tw0 = tw_cnt; dn0 = done_cnt;
        start_frame("A");
        run_issues(1'b0, -1, -1);
        wait_done("A");
        tick();
        chk("A_busy_after", 32'(busy0), 32'd0);
        chk("A_fc", 32'(fc0), 32'd1);
        chk("A_tw_cnt", 32'(tw_cnt - tw0), 32'd64);
        chk("A_done_cnt", 32'(done_cnt - dn0), 32'd1);
        chk("A_rev_cnt", 32'(idx1), 32'd64);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("tab_nat_addr_%0d", tab[i].n),
                32'(log0_addr[tab[i].n]), 32'(tab[i].n));
            chk($sformatf("tab_rev_addr_%0d", tab[i].n),
                32'(log1_addr[tab[i].n]), 32'(tab[i].rev_addr));
            if (tab[i].chk_nat)
                chk($sformatf("tab_nat_data_%0d", tab[i].n),
                    32'(log0_data[tab[i].n]), 32'(tab[i].nat_data));
            if (tab[i].chk_rev)
                chk($sformatf("tab_rev_data_%0d", tab[i].n),
                    32'(log1_data[tab[i].n]), 32'(tab[i].rev_data));
        end

        // Frame B: in_valid toggling, ROM data must hold in gaps
        tw0 = tw_cnt;
        gap_chk = 1'b1;
        start_frame("B");
        run_issues(1'b1, -1, -1);
        wait_done("B");
        tick();
        gap_chk = 1'b0;
        chk("B_fc", 32'(fc0), 32'd2);
        chk("B_tw_cnt", 32'(tw_cnt - tw0), 32'd64);

        // Frame C: stray start at n=20, then back-to-back frame D
        tw0 = tw_cnt; er0 = err_cnt;
        start_frame("C");
        run_issues(1'b0, -1, 20);
        wait_done("C");
        start_frame("D");
        chk("C_err_cnt", 32'(err_cnt - er0), 32'd1);
        chk("C_fc", 32'(fc0), 32'd3);
        chk("C_tw_cnt", 32'(tw_cnt - tw0), 32'd64);
        run_issues(1'b0, -1, -1);
        wait_done("D");
        tick();
        chk("D_fc", 32'(fc0), 32'd4);

        // start with abort in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("sa_busy", 32'(busy0), 32'd0);
        tick();
        chk("sa_err", 32'(err0), 32'd0);

        // Frame E: abort at n=30
        dn0 = done_cnt;
        start_frame("E");
        run_issues(1'b0, 30, -1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("E_busy", 32'(busy0), 32'd0);
        chk("E_tv", 32'(tv0), 32'd0);
        chk("E_addr_hold", 32'(a0), 32'd29);
        repeat (4) tick();
        chk("E_fc", 32'(fc0), 32'd4);
        chk("E_no_done", 32'(done_cnt - dn0), 32'd0);

        // Frame F: clean frame after abort starts at n=0
        tw0 = tw_cnt;
        start_frame("F");
        run_issues(1'b0, -1, -1);
        wait_done("F");
        tick();
        chk("F_fc", 32'(fc0), 32'd5);
        chk("F_tw_cnt", 32'(tw_cnt - tw0), 32'd64);

        // Frame G: asynchronous reset at n=40
        start_frame("G");
        run_issues(1'b0, 40, -1);
        #3;
        rst = 1'b1;
        sb.delete();
        #1;
        chk("G_rst_addr", 32'(a0), 32'd0);
        chk("G_rst_busy", 32'(busy0), 32'd0);
        chk("G_rst_tv", 32'(tv0), 32'd0);
        chk("G_rst_fc", 32'(fc0), 32'd0);
        chk("G_rst_first", 32'(tf0), 32'd0);
        repeat (2) @(posedge clk);
        #4;
        rst = 1'b0;
        tick();

        // Frame H: clean frame after reset
        tw0 = tw_cnt;
        start_frame("H");
        run_issues(1'b0, -1, -1);
        wait_done("H");
        tick();
        chk("H_fc", 32'(fc0), 32'd1);
        chk("H_tw_cnt", 32'(tw_cnt - tw0), 32'd64);
        repeat (3) tick();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
